seg_arbiter: RTL
================

# seg_arbiter

Round-robin arbiter that shares one segment-FSM datapath instance between up to N requesting controllers. It grants exclusive ownership to one requester at a time and enforces a bounded hold time with a timeout. It inserts a fixed dead cycle between owners so the shared FSM's `a`/`b` inputs are never driven by two masters on adjacent cycles. It sits between the requester blocks and the input mux of the shared FSM.

## Interface

**Parameters**
- `N`, default 4: number of requesters; legal range 2..8.
- `MAX_HOLD`, default 16: maximum cycles a grant may be held; legal values ≥ 2.

**Ports**
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous reset, active-low.
- `req`, in, N: per-requester request level; bit i high means requester i wants the datapath.
- `rel`, in, N: per-requester release pulse; only the current owner's bit has effect.
- `gnt`, out, N: one-hot grant; all zero when no owner.
- `gnt_vld`, out, 1: high while any `gnt` bit is high.
- `gnt_id`, out, clog2(N): index of the current or most recent owner.
- `timeout`, out, 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation

- **Registers**
  - `state` ∈ {IDLE, BUSY, GAP}.
  - `ptr`, clog2(N) bits: round-robin start index.
  - `owner`, clog2(N) bits.
  - `hold_cnt`, clog2(MAX_HOLD+1) bits.
  - All outputs are registered.
- **Reset (reset=0, asynchronous)**
  - `state`=IDLE, `ptr`=0, `hold_cnt`=0.
  - `gnt`=0, `gnt_vld`=0, `gnt_id`=0, `timeout`=0.
  - Applies immediately, including mid-grant.
- **IDLE**
  - If `req`≠0, select the first set bit scanning ptr, ptr+1, …, wrapping modulo N.
  - On the same edge: `owner`=`gnt_id`=selected index, `gnt`=one-hot(selected), `gnt_vld`=1, `hold_cnt`=1, go to BUSY.
  - If `req`=0, stay in IDLE.
- **BUSY** (evaluated each edge, in priority order)
  - **Release**: if `rel[owner]`=1 or `req[owner]`=0, then `gnt`=0, `gnt_vld`=0, `ptr`=(owner+1) mod N, go to GAP.
  - **Timeout**: else if `hold_cnt`=MAX_HOLD, then `gnt`=0, `gnt_vld`=0, `timeout`=1, `ptr`=(owner+1) mod N, go to GAP.
  - **Hold**: else `hold_cnt`+=1 and stay in BUSY.
- **GAP**
  - Lasts exactly one cycle, then go to IDLE.
  - `timeout` returns to 0 here.
  - `req` is ignored during GAP.
- **Ignored and held values**
  - `rel` bits of non-owners are ignored in every state.
  - `rel` is ignored in IDLE and GAP.
  - `gnt_id` holds the last owner after release; only `gnt_vld` indicates validity.

## Timing

- **Grant latency**: `req` sampled high in IDLE at edge t → `gnt` visible after edge t (one-cycle registered latency).
- **Hold length**: a grant is visible for at most MAX_HOLD cycles. For an owner that never releases, `gnt` is high exactly MAX_HOLD cycles.
- **Release latency**: `rel` or `req` drop sampled at edge t → `gnt`=0 after edge t.
- **Handover**: the next grant is visible no earlier than after edge t+2, giving a minimum of 2 zero-grant cycles between owners.
- **Timeout pulse**: `timeout` is high for exactly the cycle spent in GAP; `gnt_id` identifies the revoked owner during that cycle.
- **Simultaneous release and limit**: release at the same edge as `hold_cnt`=MAX_HOLD means release wins and `timeout` stays 0.
- **Sole requester after timeout**: a sole requester whose grant timed out is re-granted after GAP, since `ptr` wraps back to it. There is no lockout.
- **Wrap-around**: owner N-1 releases → `ptr`=0.
- **Output invariant**: `gnt` is never multi-hot, and `gnt_vld` equals OR(`gnt`) at all times.

## Test plan

Use N=4, MAX_HOLD=16 unless stated.

1. **Reset and first grant**: `reset` low for 2 cycles, then `req`=4'b0001 at cycle 3 → `gnt`=0001, `gnt_vld`=1, `gnt_id`=0 visible from cycle 4. All outputs were 0 during reset.
2. **Round-robin order**: `req`=4'b1111 held; each owner pulses `rel` on its 3rd grant cycle → grant sequence 0,1,2,3,0. Each grant lasts 3 cycles, with 2 zero-grant cycles between grants.
3. **Timeout**: `req`=4'b0100 held, `rel`=0 → `gnt`=0100 for exactly 16 cycles, then `timeout`=1 for one cycle with `gnt_id`=2. Requester 2 is re-granted two cycles after revocation.
4. **Release coincides with limit**: `rel[owner]` asserted in the 16th grant cycle → `gnt` drops and `timeout` remains 0.
5. **Non-owner release and request drop**: while owner=1, pulse `rel`=4'b0001 → no effect. Then drop `req[1]` → `gnt`=0 next edge, and `ptr`=2 (next grant goes to 2 if requested, else 3, 0, 1).
6. **Reset mid-grant**: `reset` low while `gnt`=0010 → `gnt`, `gnt_vld`, `gnt_id`, and `timeout` are 0 immediately, without waiting for a clock edge. After release with `req`=4'b1010 → grant goes to 1 (ptr reset to 0).

Source files
------------

// File: rtl/seg_arbiter_if.sv
// Request/grant bundle between requester blocks and the shared segment-FSM arbiter.
// Latency: none; this is wiring only.
// Backpressure: requesters hold req until granted; the grant is the only flow control.
interface seg_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  rel;
  logic [N-1:0]  gnt;
  logic          gnt_vld;
  logic [IW-1:0] gnt_id;
  logic          timeout;

  // Requester side drives requests and releases and observes the grant.
  modport master (
    output req, rel,
    input  gnt, gnt_vld, gnt_id, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, rel,
    output gnt, gnt_vld, gnt_id, timeout
  );
endinterface

// File: rtl/seg_arbiter.sv
// Round-robin owner selection for one shared segment-FSM, with a hold limit and a dead cycle between owners.
// Latency: grant and revocation are registered, visible one cycle after the deciding edge.
// Backpressure: waiting requesters stay pending on req; an owner is revoked after MAX_HOLD cycles.
module seg_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input logic         clk,
  input logic         reset,
  seg_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [N-1:0]  gnt_q, gnt_nxt;
  logic          vld_q, vld_nxt;
  logic [IW-1:0] id_q, id_nxt;
  logic          to_q, to_nxt;

  logic          found;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic          drop;
  logic          at_limit;

  // Index increment that wraps at N even when N is not a power of two.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] v);
    if (int'(v) == N - 1) return '0;
    else                  return v + IW'(1);
  endfunction

  // Scan ptr, ptr+1, ... (mod N) for the first pending request.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
      cand = next_idx(cand);
    end
  end

  // Owner gives up either by pulsing rel or by dropping its request level.
  assign drop     = bus.rel[owner] | ~bus.req[owner];
  assign at_limit = (hold_cnt == HW'(MAX_HOLD));

  // State register plus all registered outputs; reset takes effect immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
      id_q     <= '0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      gnt_q    <= gnt_nxt;
      vld_q    <= vld_nxt;
      id_q     <= id_nxt;
      to_q     <= to_nxt;
    end
  end

  // Next-state: release has priority over the hold limit; GAP always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (drop || at_limit) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the grant outputs and bookkeeping for the current transition.
  always_comb begin
    ptr_nxt   = ptr;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt_q;
    vld_nxt   = vld_q;
    id_nxt    = id_q;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt    = sel;
          id_nxt       = sel;
          gnt_nxt      = '0;
          gnt_nxt[sel] = 1'b1;
          vld_nxt      = 1'b1;
          hold_nxt     = HW'(1);
        end
      end
      BUSY: begin
        if (drop || at_limit) begin
          gnt_nxt = '0;
          vld_nxt = 1'b0;
          ptr_nxt = next_idx(owner);
          to_nxt  = ~drop;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: begin
        gnt_nxt = '0;
        vld_nxt = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = vld_q;
  assign bus.gnt_id  = id_q;
  assign bus.timeout = to_q;
endmodule
